i2s_piso_tx: RTL and testbench

Parametrised stereo parallel-to-serial transmitter for the I2S audio path. It accepts one left/right sample pair per frame through a valid/ready holding register. It generates the serial bit clock (`sck`) and word select (`ws`) from the system clock and shifts data out MSB-first, with standard I2S one-bit `ws` lead. It sits between the sample source and the external DAC/codec pins and adds continuous framing, underrun signalling and a clean start/stop under `enable`.

---
 rtl/i2s_piso_tx.sv | 150 +++++++++++++++
 tb/tb_i2s_piso_tx.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_piso_tx.sv
// Stereo I2S parallel-to-serial transmitter with a one-entry sample holding register.
// Define I2S_PISO_LJ_MODE_EN for left-justified word select (no one-bit ws lead).
module i2s_piso_tx #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned CLK_DIV = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] din_l,
    input  logic [WIDTH-1:0] din_r,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sck,
    output logic             ws,
    output logic             sd,
    output logic             busy,
    output logic             underrun
);

    localparam int unsigned FW = 2 * WIDTH;
    localparam int unsigned BW = $clog2(FW);
    localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [BW-1:0] BMAX = BW'(FW - 1);
    localparam logic [DW-1:0] DMAX = DW'(CLK_DIV - 1);

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    state_t          state_q, state_d;
    logic [FW-1:0]   hold_q, hold_d;
    logic            full_q, full_d;
    logic [FW-1:0]   shift_q, shift_d;
    logic [DW-1:0]   div_q, div_d;
    logic [BW-1:0]   bit_q, bit_d;
    logic            sck_q, sck_d;
    logic            ws_q, ws_d;
    logic            und_q, und_d;
    logic [BW-1:0]   bit_nxt;

    // Word select for the bit about to be driven at bit position b.
    function automatic logic ws_of(input logic [BW-1:0] b);
`ifdef I2S_PISO_LJ_MODE_EN
        return (32'(b) >= WIDTH);
`else
        return (((32'(b) + 32'd1) % FW) >= WIDTH);
`endif
    endfunction

    assign bit_nxt = bit_q + BW'(1);

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        full_d  = full_q;
        shift_d = shift_q;
        div_d   = div_q;
        bit_d   = bit_q;
        sck_d   = sck_q;
        ws_d    = ws_q;
        und_d   = 1'b0;

        if (din_valid && !full_q) begin
            hold_d = {din_l, din_r};
            full_d = 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                sck_d   = 1'b0;
                ws_d    = 1'b0;
                shift_d = '0;
                div_d   = '0;
                bit_d   = '0;
                if (enable && full_q) begin
                    state_d = S_RUN;
                    shift_d = hold_q;
                    full_d  = 1'b0;
                    ws_d    = ws_of('0);
                end
            end
            S_RUN: begin
                if (div_q == DMAX) begin
                    div_d = '0;
                    sck_d = !sck_q;
                    // Falling sck edge: advance the bit, or handle the frame boundary.
                    if (sck_q) begin
                        if (bit_q != BMAX) begin
                            shift_d = {shift_q[FW-2:0], 1'b0};
                            bit_d   = bit_nxt;
                            ws_d    = ws_of(bit_nxt);
                        end else if (!enable) begin
                            state_d = S_IDLE;
                            shift_d = '0;
                            bit_d   = '0;
                            ws_d    = 1'b0;
                        end else begin
                            bit_d = '0;
                            ws_d  = ws_of('0);
                            if (full_q) begin
                                shift_d = hold_q;
                                full_d  = 1'b0;
                            end else begin
                                shift_d = '0;
                                und_d   = 1'b1;
                            end
                        end
                    end
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            hold_q  <= '0;
            full_q  <= 1'b0;
            shift_q <= '0;
            div_q   <= '0;
            bit_q   <= '0;
            sck_q   <= 1'b0;
            ws_q    <= 1'b0;
            und_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            full_q  <= full_d;
            shift_q <= shift_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            sck_q   <= sck_d;
            ws_q    <= ws_d;
            und_q   <= und_d;
        end
    end

    assign din_ready = !full_q;
    assign sck       = sck_q;
    assign ws        = ws_q;
    assign sd        = shift_q[FW-1];
    assign busy      = (state_q == S_RUN);
    assign underrun  = und_q;

endmodule

// File: tb/tb_i2s_piso_tx.sv
// Bench for i2s_piso_tx: a receiver-side monitor rebuilds frames on sck rising edges
// and checks them, plus framing and timing, against a queue of handshaken sample pairs.
module tb_i2s_piso_tx;

    localparam int unsigned W         = 16;
    localparam int unsigned CD        = 2;
    localparam int unsigned FW        = 2 * W;
    localparam int unsigned FRAME_CLK = 4 * W * CD;
    localparam int unsigned BUDGET    = 4 * FRAME_CLK;

    logic         clk = 1'b0;
    logic         reset;
    logic         enable;
    logic [W-1:0] din_l;
    logic [W-1:0] din_r;
    logic         din_valid;
    logic         din_ready;
    logic         sck;
    logic         ws;
    logic         sd;
    logic         busy;
    logic         underrun;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    always #5 clk = ~clk;

    i2s_piso_tx #(.WIDTH(W), .CLK_DIV(CD)) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .din_l     (din_l),
        .din_r     (din_r),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .sck       (sck),
        .ws        (ws),
        .sd        (sd),
        .busy      (busy),
        .underrun  (underrun)
    );

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic exp_ws(input int unsigned i);
`ifdef I2S_PISO_LJ_MODE_EN
        return (i >= W);
`else
        return (((i + 1) % FW) >= W);
`endif
    endfunction

    // Receiver model state
    int unsigned   cyc = 0;
    int unsigned   bit_idx = 0;
    int unsigned   busy_cyc = 0;
    int unsigned   prev0 = 0;
    int unsigned   und_cnt = 0;
    logic          have_prev0 = 1'b0;
    logic          first_rise = 1'b0;
    logic          busy_p = 1'b0, sck_p = 1'b0, sd_p = 1'b0, ws_p = 1'b0;
    logic          und_p = 1'b0, ready_p = 1'b1;
    logic [FW-1:0] word = '0;
    logic [FW-1:0] rxq[$];
    logic [FW-1:0] expq[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reset) begin
            bit_idx = 0; word = '0; busy_p = 1'b0; sck_p = 1'b0; sd_p = 1'b0;
            ws_p = 1'b0; und_p = 1'b0; ready_p = 1'b1; have_prev0 = 1'b0; first_rise = 1'b0;
        end else begin
            if (busy && !busy_p) begin
                bit_idx = 0; word = '0; busy_cyc = cyc; have_prev0 = 1'b0; first_rise = 1'b1;
                if (!ready_p) check_eq("ready_after_entry", din_ready, 1);
            end
            if (busy && busy_p && !(sck_p && !sck))
                check_eq("sd_ws_stable", {sd, ws}, {sd_p, ws_p});
            if (busy && sck && !sck_p) begin
                if (first_rise) begin
                    check_eq("first_sck_delay", cyc - busy_cyc, CD);
                    first_rise = 1'b0;
                end
                check_eq("ws_bit", ws, exp_ws(bit_idx));
                word = {word[FW-2:0], sd};
                if (bit_idx == 0) begin
                    if (have_prev0) check_eq("frame_period", cyc - prev0, FRAME_CLK);
                    prev0 = cyc;
                    have_prev0 = 1'b1;
                end
                if (bit_idx == FW - 1) begin
                    rxq.push_back(word);
                    bit_idx = 0;
                end else begin
                    bit_idx++;
                end
            end
            if (busy && busy_p && sck_p && !sck && bit_idx == 0 && !ready_p)
                check_eq("ready_after_boundary", din_ready, 1);
            if (!busy && busy_p)
                check_eq("idle_outputs", {sck, ws, sd, underrun}, 4'b0);
            if (underrun) begin
                und_cnt++;
                check_eq("underrun_width", und_p, 0);
                check_eq("underrun_sd", {busy, sd}, 2'b10);
            end
            busy_p = busy; sck_p = sck; sd_p = sd; ws_p = ws; und_p = underrun; ready_p = din_ready;
        end
    end

    task automatic send_pair(input logic [W-1:0] l, input logic [W-1:0] r);
        int unsigned n = 0;
        @(negedge clk);
        while (!din_ready && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        check_eq("ready_wait", din_ready, 1);
        repeat ($urandom_range(0, 40)) @(negedge clk);
        din_l = l;
        din_r = r;
        din_valid = 1'b1;
        @(negedge clk);
        din_valid = 1'b0;
        check_eq("ready_fall", din_ready, 0);
    endtask

    task automatic wait_busy(input logic val);
        int unsigned n = 0;
        while (busy !== val && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        check_eq("busy_wait", busy, val);
    endtask

    task automatic wait_bit(input int unsigned target);
        int unsigned n = 0;
        while (bit_idx != target && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        check_eq("bit_wait", bit_idx, target);
    endtask

    task automatic compare_frames();
        check_eq("frame_count", rxq.size(), expq.size());
        for (int i = 0; i < expq.size() && i < rxq.size(); i++)
            check_eq("frame_data", rxq[i], expq[i]);
        rxq.delete();
        expq.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int unsigned und_base;
        logic [W-1:0] l, r;

        reset = 1'b1; enable = 1'b0; din_valid = 1'b0; din_l = '0; din_r = '0;
        repeat (3) @(negedge clk);
        check_eq("reset_outputs", {sck, ws, sd, busy, underrun}, 5'b0);
        check_eq("reset_ready", din_ready, 1);
        reset = 1'b0;
        @(negedge clk);
        check_eq("post_reset_outputs", {sck, ws, sd, busy, underrun, din_ready}, 6'b000001);

        // Back-to-back random pairs, then a single underrun frame
        und_base = und_cnt;
        enable = 1'b1;
        send_pair(16'hA5C3, 16'h0F01);
        expq.push_back({16'hA5C3, 16'h0F01});
        check_eq("entry_pending", busy, 0);
        @(negedge clk);
        check_eq("entry_run", busy, 1);
        for (int i = 0; i < 5; i++) begin
            l = W'($urandom);
            r = W'($urandom);
            send_pair(l, r);
            expq.push_back({l, r});
        end
        begin
            int unsigned n = 0;
            while (und_cnt == und_base && n < BUDGET) begin
                @(negedge clk);
                n++;
            end
        end
        check_eq("underrun_seen", und_cnt - und_base, 1);
        expq.push_back('0);
        enable = 1'b0;
        wait_busy(1'b0);
        compare_frames();
        check_eq("underrun_total", und_cnt - und_base, 1);

        // Enable dropped early in a frame; a queued pair must stay held
        und_base = und_cnt;
        enable = 1'b1;
        l = W'($urandom); r = W'($urandom);
        send_pair(l, r);
        expq.push_back({l, r});
        wait_bit(6);
        enable = 1'b0;
        l = W'($urandom); r = W'($urandom);
        send_pair(l, r);
        wait_busy(1'b0);
        repeat (10) @(negedge clk);
        check_eq("idle_quiet", {busy, sck, ws, sd}, 4'b0);
        check_eq("held_ready", din_ready, 0);
        compare_frames();
        expq.push_back({l, r});
        enable = 1'b1;
        wait_busy(1'b1);
        enable = 1'b0;
        wait_busy(1'b0);
        compare_frames();
        check_eq("no_underrun_drop", und_cnt - und_base, 0);

        // Reset in the middle of a frame, then a clean restart
        und_base = und_cnt;
        enable = 1'b1;
        send_pair(W'($urandom), W'($urandom));
        wait_bit(21);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check_eq("reset_midframe", {sck, ws, sd, busy, underrun, din_ready}, 6'b000001);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        rxq.delete();
        expq.delete();
        l = W'($urandom); r = W'($urandom);
        send_pair(l, r);
        expq.push_back({l, r});
        wait_bit(1);
        enable = 1'b0;
        wait_busy(1'b0);
        compare_frames();
        check_eq("no_underrun_reset", und_cnt - und_base, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
